// File: rtl/adler32_pkg.sv
// Shared Adler-32 constants and checker state encoding, common to the
// adler32 generator and the adler32_chk trailer checker.
package adler32_pkg;

   localparam logic [15:0] ADLER_MOD  = 16'd65521;
   localparam logic [31:0] ADLER_INIT = 32'h0000_0001;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RUN  = 3'd1,
      ST_BYTE = 3'd2,
      ST_WREF = 3'd3,
      ST_DONE = 3'd4
   } chk_state_t;

endpackage

// File: rtl/adler32_step.sv
// Single-byte Adler-32 update. Inputs are already reduced (< 65521), so each
// running sum stays below 2*65521 and one conditional subtract is enough.
module adler32_step
   import adler32_pkg::*;
(
   input  logic [15:0] s1_i,
   input  logic [15:0] s2_i,
   input  logic [7:0]  byte_i,
   output logic [15:0] s1_o,
   output logic [15:0] s2_o
);

   logic [16:0] sum1;
   logic [16:0] sum2;

   // s1' = (s1 + b) mod 65521, then s2' = (s2 + s1') mod 65521
   always_comb begin
      sum1 = {1'b0, s1_i} + {9'b0, byte_i};
      if (sum1 >= {1'b0, ADLER_MOD})
         s1_o = sum1[15:0] - ADLER_MOD;
      else
         s1_o = sum1[15:0];
      sum2 = {1'b0, s2_i} + {1'b0, s1_o};
      if (sum2 >= {1'b0, ADLER_MOD})
         s2_o = sum2[15:0] - ADLER_MOD;
      else
         s2_o = sum2[15:0];
   end

endmodule

// File: rtl/adler32_chk.sv
// Adler-32 trailer checker: serialises incoming beats one byte per cycle,
// accumulates s1/s2 and compares {s2,s1} against the captured trailer word.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no stream in progress; beats and trailer words ignored
//   RUN   | waiting for a data beat (rdy_o=1)
//   BYTE  | consuming one byte per cycle of the registered beat
//   WREF  | data complete, waiting for the trailer word to be captured
//   DONE  | one-cycle result pulse (done_o/val_o), results held afterwards
module adler32_chk #(
   parameter int DATA_WD = 32,
   parameter int NUM_WD  = 2
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start_i,
   input  logic               val_i,
   output logic               rdy_o,
   input  logic [DATA_WD-1:0] dat_i,
   input  logic [NUM_WD-1:0]  num_i,
   input  logic               lst_i,
   input  logic               ref_val_i,
   input  logic [DATA_WD-1:0] ref_dat_i,
   output logic               done_o,
   output logic               val_o,
   output logic [DATA_WD-1:0] dat_o,
   output logic               ok_o
);
   import adler32_pkg::*;

   chk_state_t         state;
   chk_state_t         state_nx;

   logic [DATA_WD-1:0] dat_q;
   logic [NUM_WD-1:0]  num_q;
   logic [NUM_WD-1:0]  idx_q;
   logic               lst_q;
   logic [15:0]        s1_q;
   logic [15:0]        s2_q;
   logic [15:0]        s1_nx;
   logic [15:0]        s2_nx;
   logic [DATA_WD-1:0] ref_q;
   logic               ref_flag;

   logic               last_byte;
   logic               load_beat;
   logic               byte_en;
   logic               res_load;
   logic [DATA_WD-1:0] dat_sh;
   logic [7:0]         byte_cur;

   assign last_byte = (idx_q == num_q);
   // byte0 sits in the top lane; shift the selected byte up to it
   assign dat_sh    = dat_q << {idx_q, 3'b000};
   assign byte_cur  = dat_sh[DATA_WD-1 -: 8];

   adler32_step u_step (
      .s1_i   (s1_q),
      .s2_i   (s2_q),
      .byte_i (byte_cur),
      .s1_o   (s1_nx),
      .s2_o   (s2_nx)
   );

   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   // next-state and control decode; a final beat blocks further acceptance
   // so a handshake never drops a beat after the stream's last byte
   always_comb begin
      state_nx  = state;
      rdy_o     = 1'b0;
      done_o    = 1'b0;
      val_o     = 1'b0;
      load_beat = 1'b0;
      byte_en   = 1'b0;
      res_load  = 1'b0;
      case (state)
         ST_IDLE: ;
         ST_RUN: begin
            rdy_o = 1'b1;
            if (val_i) begin
               load_beat = 1'b1;
               state_nx  = ST_BYTE;
            end
         end
         ST_BYTE: begin
            byte_en = 1'b1;
            rdy_o   = last_byte & ~lst_q;
            if (last_byte) begin
               if (lst_q)
                  state_nx = ST_WREF;
               else if (val_i) begin
                  load_beat = 1'b1;
                  state_nx  = ST_BYTE;
               end else
                  state_nx = ST_RUN;
            end
         end
         ST_WREF: begin
            if (ref_flag) begin
               res_load = 1'b1;
               state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            done_o   = 1'b1;
            val_o    = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
      if (start_i) begin
         state_nx  = ST_RUN;
         load_beat = 1'b0;
         res_load  = 1'b0;
      end
   end

   // beat register and byte index
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dat_q <= '0;
         num_q <= '0;
         lst_q <= 1'b0;
         idx_q <= '0;
      end else if (load_beat) begin
         dat_q <= dat_i;
         num_q <= num_i;
         lst_q <= lst_i;
         idx_q <= '0;
      end else if (byte_en && !last_byte) begin
         idx_q <= idx_q + 1'b1;
      end
   end

   // running sums, restarted by start_i
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_q <= ADLER_INIT[15:0];
         s2_q <= ADLER_INIT[31:16];
      end else if (start_i) begin
         s1_q <= ADLER_INIT[15:0];
         s2_q <= ADLER_INIT[31:16];
      end else if (byte_en) begin
         s1_q <= s1_nx;
         s2_q <= s2_nx;
      end
   end

   // trailer capture; accepted in any active state, latest word wins
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ref_q    <= '0;
         ref_flag <= 1'b0;
      end else if (start_i) begin
         ref_flag <= 1'b0;
      end else if (ref_val_i && state != ST_IDLE) begin
         ref_q    <= ref_dat_i;
         ref_flag <= 1'b1;
      end
   end

   // result registers, loaded on entry to DONE and held until the next start
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dat_o <= '0;
         ok_o  <= 1'b0;
      end else if (start_i) begin
         dat_o <= '0;
         ok_o  <= 1'b0;
      end else if (res_load) begin
         dat_o <= {s2_q, s1_q};
         ok_o  <= ({s2_q, s1_q} == ref_q);
      end
   end

endmodule

// File: tb/tb_adler32_chk.sv
// Self-checking bench for adler32_chk: streams are modelled in software,
// expected results are queued when driven and compared on each done_o pulse.
module tb_adler32_chk;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start_i = 1'b0;
   logic        val_i = 1'b0;
   logic        rdy_o;
   logic [31:0] dat_i = '0;
   logic [1:0]  num_i = '0;
   logic        lst_i = 1'b0;
   logic        ref_val_i = 1'b0;
   logic [31:0] ref_dat_i = '0;
   logic        done_o;
   logic        val_o;
   logic [31:0] dat_o;
   logic        ok_o;

   typedef struct packed {
      logic [31:0] dat;
      logic        ok;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  stream[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   int          n_done = 0;

   always #5 clk = ~clk;

   adler32_chk #(.DATA_WD(32), .NUM_WD(2)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .start_i   (start_i),
      .val_i     (val_i),
      .rdy_o     (rdy_o),
      .dat_i     (dat_i),
      .num_i     (num_i),
      .lst_i     (lst_i),
      .ref_val_i (ref_val_i),
      .ref_dat_i (ref_dat_i),
      .done_o    (done_o),
      .val_o     (val_o),
      .dat_o     (dat_o),
      .ok_o      (ok_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] model_adler();
      int a = 1;
      int b = 0;
      foreach (stream[i]) begin
         a = (a + int'(stream[i])) % 65521;
         b = (b + a) % 65521;
      end
      return {b[15:0], a[15:0]};
   endfunction

   // compare every result pulse against the oldest queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (rstn && done_o) begin
         n_done++;
         if (sb.size() == 0)
            chk("unexpected_done", 32'd0, 32'd1);
         else begin
            e = sb.pop_front();
            chk("dat_o", dat_o, e.dat);
            chk("ok_o", {31'd0, ok_o}, {31'd0, e.ok});
            chk("val_o", {31'd0, val_o}, 32'd1);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // all tasks start and end at a falling edge
   task automatic do_start();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic do_ref(input logic [31:0] w);
      ref_val_i = 1'b1;
      ref_dat_i = w;
      @(negedge clk);
      ref_val_i = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [1:0] n, input logic l,
                            output int waits);
      val_i = 1'b1;
      dat_i = d;
      num_i = n;
      lst_i = l;
      waits = 0;
      while (!rdy_o && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      if (!rdy_o) chk("beat_timeout", 32'd0, 32'd1);
      @(negedge clk);
      val_i = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done_o && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (!done_o) chk("done_timeout", 32'd0, 32'd1);
   endtask

   // drive the current stream in beats of `chunk` bytes; lat counts falling
   // edges from the return of the final beat (or of the late trailer) to done_o
   task automatic run_stream(input int chunk, input logic [31:0] refw,
                             input bit ref_first, output int lat);
      exp_t        e;
      logic [31:0] w;
      int          cnt;
      int          prev;
      int          waits;
      int          n;
      n = stream.size();
      e.dat = model_adler();
      e.ok  = (e.dat == refw);
      do_start();
      if (ref_first) do_ref(refw);
      sb.push_back(e);
      prev = 0;
      for (int i = 0; i < n; i += chunk) begin
         cnt = (n - i < chunk) ? n - i : chunk;
         w = '0;
         for (int j = 0; j < cnt; j++) w[31-8*j -: 8] = stream[i+j];
         send_beat(w, 2'(cnt - 1), (i + cnt == n), waits);
         if (i > 0) chk("rdy_wait", waits, prev - 1);
         prev = cnt;
      end
      if (!ref_first) begin
         repeat (6) @(negedge clk);
         do_ref(refw);
      end
      wait_done(lat);
      @(negedge clk);
      chk("done_pulse_width", {31'd0, done_o}, 32'd0);
      chk("dat_hold", dat_o, e.dat);
      chk("ok_hold", {31'd0, ok_o}, {31'd0, e.ok});
   endtask

   task automatic load_str(input string s);
      stream.delete();
      for (int i = 0; i < s.len(); i++) stream.push_back(s[i]);
   endtask

   initial begin
      int lat;
      int waits;
      int d0;

      repeat (2) @(negedge clk);
      chk("rst_rdy", {31'd0, rdy_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_val", {31'd0, val_o}, 32'd0);
      chk("rst_dat", dat_o, 32'd0);
      chk("rst_ok", {31'd0, ok_o}, 32'd0);
      rstn = 1'b1;
      @(negedge clk);

      // "a", known trailer value
      load_str("a");
      chk("model_a", model_adler(), 32'h0062_0062);
      run_stream(4, 32'h0062_0062, 1'b1, lat);

      // "abc": matching trailer then mismatching trailer, trailer after data
      load_str("abc");
      run_stream(4, 32'h024D_0127, 1'b0, lat);
      chk("lat_ref_late", lat, 1);
      run_stream(4, 32'h024D_0128, 1'b0, lat);

      // "Wikipedia" in 4/4/1 beats, back-to-back
      load_str("Wikipedia");
      chk("model_wiki", model_adler(), 32'h11E6_0398);
      run_stream(4, 32'h11E6_0398, 1'b1, lat);
      chk("lat_last_byte", lat, 2);

      // 8192 bytes of 0xFF, wraps both sums
      stream.delete();
      for (int i = 0; i < 8192; i++) stream.push_back(8'hFF);
      run_stream(4, model_adler(), 1'b1, lat);

      // odd-sized beats over a pseudo-random stream
      stream.delete();
      for (int i = 0; i < 37; i++) stream.push_back(8'($urandom_range(0, 255)));
      run_stream(3, model_adler(), 1'b1, lat);
      run_stream(2, model_adler() ^ 32'h1, 1'b0, lat);

      // restart mid-stream: only the second stream reports
      d0 = n_done;
      do_start();
      do_ref(32'h1234_5678);
      send_beat(32'h7778_797A, 2'd3, 1'b0, waits);
      load_str("abc");
      run_stream(4, 32'h024D_0127, 1'b1, lat);
      chk("abort_done_cnt", n_done - d0, 1);

      // asynchronous reset while serialising the last byte of a beat
      do_start();
      do_ref(32'h0062_0062);
      send_beat(32'h6162_6364, 2'd3, 1'b0, waits);
      repeat (3) @(negedge clk);
      chk("rdy_pre_rst", {31'd0, rdy_o}, 32'd1);
      #1 rstn = 1'b0;
      #1;
      chk("mid_rst_rdy", {31'd0, rdy_o}, 32'd0);
      chk("mid_rst_done", {31'd0, done_o}, 32'd0);
      chk("mid_rst_dat", dat_o, 32'd0);
      chk("mid_rst_ok", {31'd0, ok_o}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", {31'd0, rdy_o}, 32'd0);
      load_str("a");
      run_stream(4, 32'h0062_0062, 1'b1, lat);

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
